// File: rtl/ram_b16_s9_pkg.sv
// Shared constants and write-mode decoding for the ram_b16_s9 block RAM model.
package ram_b16_s9_pkg;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 8;

  // Behaviour of the data output during a write cycle.
  typedef enum logic [1:0] {
    WRITE_FIRST = 2'd0,
    READ_FIRST  = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_e;

  // Maps the WRITE_MODE string parameter onto the enumeration.
  // Unknown strings fall back to WRITE_FIRST.
  function automatic write_mode_e decode_write_mode(input string mode);
    if (mode == "READ_FIRST") return READ_FIRST;
    if (mode == "NO_CHANGE")  return NO_CHANGE;
    return WRITE_FIRST;
  endfunction

  // True when the string names one of the three supported modes.
  function automatic bit is_valid_write_mode(input string mode);
    return (mode == "WRITE_FIRST") || (mode == "READ_FIRST") || (mode == "NO_CHANGE");
  endfunction

endpackage

// File: rtl/ram_b16_s9_array.sv
// Address-indexed storage array: synchronous write, combinational read of the
// addressed word. The read value seen at a clock edge is the pre-write content.
module ram_b16_s9_array
  import ram_b16_s9_pkg::*;
#(
  parameter int unsigned W = DW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the addressed word on an enabled write edge.
  // NOTE: the array has no reset on purpose; a reset would stop it mapping onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_b16_s9.sv
// ram_b16_s9: 2048 x (8 data + 1 parity) single-port synchronous block RAM.
// The output register {DOP, DO} powers up to INIT, is loaded with SRVAL by SSR,
// and otherwise follows reads or the WRITE_MODE rule on writes.
// Build option: define RAM_B16_S9_PARITY_EN to store the parity column; without
// it DIP is ignored and DOP only carries INIT[8]/SRVAL[8], otherwise 0.
module ram_b16_s9
  import ram_b16_s9_pkg::*;
#(
  parameter logic [DW:0] INIT       = 9'h000,
  parameter logic [DW:0] SRVAL      = 9'h000,
  parameter string       WRITE_MODE = "WRITE_FIRST"
) (
  input  logic          CLK,
  input  logic          SSR,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DI,
  input  logic          DIP,
  input  logic          EN,
  input  logic          WE,
  output logic [DW-1:0] DO,
  output logic          DOP
);

  localparam write_mode_e MODE = decode_write_mode(WRITE_MODE);

  if (!is_valid_write_mode(WRITE_MODE)) begin : g_bad_mode
    $warning("ram_b16_s9: unknown WRITE_MODE, behaving as WRITE_FIRST");
  end

  // NOTE: the declaration initialiser is the power-up value of the output register;
  // this primitive has no reset input, SSR is an output load, not a reset.
  logic [DW:0] dout_q = INIT;
  logic [DW:0] dout_d;
  logic [DW:0] wr_word;
  logic [DW:0] rd_word;
  logic        mem_we;

  assign mem_we = EN & WE;

`ifdef RAM_B16_S9_PARITY_EN
  // Parity column stored alongside the data byte.
  logic [DW:0] arr_rdata;

  assign wr_word = {DIP, DI};
  assign rd_word = arr_rdata;

  ram_b16_s9_array #(
    .W (DW + 1)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .addr_i  (ADDR),
    .wdata_i (wr_word),
    .rdata_o (arr_rdata)
  );
`else
  // Data-only array; the parity column reads as 0.
  logic [DW-1:0] arr_rdata;
  logic          unused_dip;

  assign unused_dip = DIP;
  assign wr_word    = {1'b0, DI};
  assign rd_word    = {1'b0, arr_rdata};

  ram_b16_s9_array #(
    .W (DW)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .addr_i  (ADDR),
    .wdata_i (DI),
    .rdata_o (arr_rdata)
  );
`endif

  // Next output value: SSR beats read data, writes follow WRITE_MODE, EN=0 freezes.
  // NOTE: defaulting dout_d to the held value first keeps this block free of latches.
  always_comb begin
    dout_d = dout_q;
    if (EN) begin
      if (SSR) begin
        dout_d = SRVAL;
      end else if (!WE) begin
        dout_d = rd_word;
      end else begin
        case (MODE)
          READ_FIRST: dout_d = rd_word;
          NO_CHANGE:  dout_d = dout_q;
          default:    dout_d = wr_word;
        endcase
      end
    end
  end

  // Output register update.
  always_ff @(posedge CLK) begin
    dout_q <= dout_d;
  end

  assign DO  = dout_q[DW-1:0];
  assign DOP = dout_q[DW];

endmodule

// File: tb/tb_ram_b16_s9.sv
// Self-checking bench for ram_b16_s9: three instances (one per WRITE_MODE) share
// stimulus; a reference model pushes expected {DOP, DO} per edge into a queue
// and a monitor on the falling edge pops and compares.
module tb_ram_b16_s9;

  localparam logic [8:0] INIT_V  = 9'h1A5;
  localparam logic [8:0] SRVAL_V = 9'h000;
`ifdef RAM_B16_S9_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        ssr = 1'b0;
  logic [10:0] addr = '0;
  logic [7:0]  di = '0;
  logic        dip = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  do_wf, do_rf, do_nc;
  logic        dop_wf, dop_rf, dop_nc;

  always #5 clk = ~clk;

  ram_b16_s9 #(.INIT(INIT_V), .SRVAL(SRVAL_V), .WRITE_MODE("WRITE_FIRST")) dut_wf (
    .CLK(clk), .SSR(ssr), .ADDR(addr), .DI(di), .DIP(dip), .EN(en), .WE(we),
    .DO(do_wf), .DOP(dop_wf));
  ram_b16_s9 #(.INIT(INIT_V), .SRVAL(SRVAL_V), .WRITE_MODE("READ_FIRST")) dut_rf (
    .CLK(clk), .SSR(ssr), .ADDR(addr), .DI(di), .DIP(dip), .EN(en), .WE(we),
    .DO(do_rf), .DOP(dop_rf));
  ram_b16_s9 #(.INIT(INIT_V), .SRVAL(SRVAL_V), .WRITE_MODE("NO_CHANGE")) dut_nc (
    .CLK(clk), .SSR(ssr), .ADDR(addr), .DI(di), .DIP(dip), .EN(en), .WE(we),
    .DO(do_nc), .DOP(dop_nc));

  // Expected outputs of the three instances (0=WRITE_FIRST, 1=READ_FIRST, 2=NO_CHANGE).
  typedef struct {
    string            name;
    logic [2:0][8:0]  exp;
    logic [2:0]       known;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: memory words with a "has been written" flag, and the
  // expected output of each instance.
  logic [8:0]      m_mem   [2048];
  bit              m_known [2048];
  logic [2:0][8:0] m_out;
  logic [2:0]      m_out_known;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {DOP,DO}=%03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of stimulus; model update and expectation push happen on the edge.
  task automatic step(input string name, input bit e, input bit w, input bit s,
                      input logic [10:0] a, input logic [7:0] d, input bit p);
    exp_t       x;
    logic [8:0] wword;
    @(negedge clk);
    en = e; we = w; ssr = s; addr = a; di = d; dip = p;
    @(posedge clk);
    wword = {(PAR ? p : 1'b0), d};
    if (e) begin
      if (s) begin
        for (int k = 0; k < 3; k++) begin
          m_out[k] = SRVAL_V;
          m_out_known[k] = 1'b1;
        end
      end else if (!w) begin
        for (int k = 0; k < 3; k++) begin
          m_out[k] = m_mem[a];
          m_out_known[k] = m_known[a];
        end
      end else begin
        m_out[0] = wword;     m_out_known[0] = 1'b1;
        m_out[1] = m_mem[a];  m_out_known[1] = m_known[a];
      end
      if (w) begin
        m_mem[a]   = wword;
        m_known[a] = 1'b1;
      end
    end
    x.name  = name;
    x.exp   = m_out;
    x.known = m_out_known;
    sb_q.push_back(x);
  endtask

  // Monitor: compare each instance against the oldest expectation, away from the edge.
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      if (x.known[0]) check({x.name, "/wf"}, {dop_wf, do_wf}, x.exp[0]);
      if (x.known[1]) check({x.name, "/rf"}, {dop_rf, do_rf}, x.exp[1]);
      if (x.known[2]) check({x.name, "/nc"}, {dop_nc, do_nc}, x.exp[2]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x0;
    for (int i = 0; i < 2048; i++) begin
      m_mem[i]   = 9'h000;
      m_known[i] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      m_out[k] = INIT_V;
      m_out_known[k] = 1'b1;
    end
    // Power-up value, observed before any edge.
    x0.name = "powerup0"; x0.exp = m_out; x0.known = m_out_known;
    sb_q.push_back(x0);

    // EN low for three edges: output holds INIT.
    repeat (3) step("powerup_en0", 1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0);

    // Top address write then read.
    step("wr_7ff", 1'b1, 1'b1, 1'b0, 11'h7FF, 8'h3C, 1'b1);
    step("rd_7ff", 1'b1, 1'b0, 1'b0, 11'h7FF, 8'h00, 1'b0);

    // Write-mode behaviour on addr 5 (prior DO = read of 7FF).
    step("wr_5_11", 1'b1, 1'b1, 1'b0, 11'd5, 8'h11, 1'b0);
    step("rd_7ff_b", 1'b1, 1'b0, 1'b0, 11'h7FF, 8'h00, 1'b0);
    step("wr_5_22", 1'b1, 1'b1, 1'b0, 11'd5, 8'h22, 1'b1);
    step("rd_5", 1'b1, 1'b0, 1'b0, 11'd5, 8'h00, 1'b0);

    // SSR with a simultaneous write: output SRVAL, write still lands.
    step("ssr_wr_9", 1'b1, 1'b1, 1'b1, 11'd9, 8'h77, 1'b0);
    step("rd_9", 1'b1, 1'b0, 1'b0, 11'd9, 8'h00, 1'b0);

    // SSR in the middle of a read sequence only affects that edge.
    step("ssr_mid", 1'b1, 1'b0, 1'b1, 11'd5, 8'h00, 1'b0);
    step("rd_after_ssr", 1'b1, 1'b0, 1'b0, 11'h7FF, 8'h00, 1'b0);

    // EN low blocks writes and freezes the output.
    step("wr_0_01", 1'b1, 1'b1, 1'b0, 11'd0, 8'h01, 1'b0);
    step("en0_wr_ff", 1'b0, 1'b1, 1'b0, 11'd0, 8'hFF, 1'b1);
    step("en0_wr_ff2", 1'b0, 1'b1, 1'b1, 11'd0, 8'hFF, 1'b1);
    step("rd_0", 1'b1, 1'b0, 1'b0, 11'd0, 8'h00, 1'b0);

    // Full address sweep: write then read back every word.
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] a;
      a = 11'(i);
      step("sweep_wr", 1'b1, 1'b1, 1'b0, a, a[7:0] ^ 8'h5A, a[0]);
    end
    for (int i = 0; i < 2048; i++) begin
      step("sweep_rd", 1'b1, 1'b0, 1'b0, 11'(i), 8'h00, 1'b0);
    end

    // Randomised mix of reads, writes, SSR and idle cycles.
    for (int i = 0; i < 600; i++) begin
      bit r_en, r_we, r_ssr;
      r_en  = ($urandom_range(0, 7) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_ssr = ($urandom_range(0, 9) == 0);
      step("random", r_en, r_we, r_ssr, 11'($urandom_range(0, 2047)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
